// File: rtl/mem_lsu_pkg.sv
// Shared constants for the MEM-stage load/store unit: operation codes,
// exception bit positions, stall polarity and FSM state encoding.
package mem_lsu_pkg;

    localparam int REG_BUS      = 32;
    localparam int REG_ADDR_BUS = 5;
    localparam int ALUOP_BUS    = 8;

    localparam logic [ALUOP_BUS-1:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [ALUOP_BUS-1:0] EXE_ADD_OP = 8'b0010_0000;
    localparam logic [ALUOP_BUS-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [ALUOP_BUS-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [ALUOP_BUS-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [ALUOP_BUS-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [ALUOP_BUS-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [ALUOP_BUS-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [ALUOP_BUS-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [ALUOP_BUS-1:0] EXE_SW_OP  = 8'b1110_1011;

    localparam int EXC_LOAD_MISALIGN  = 4;
    localparam int EXC_STORE_MISALIGN = 5;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUSY = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store lane select/replication, load lane
// extraction with sign/zero extension, and misalignment detection.
module lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [ALUOP_BUS-1:0] i_aluop,
    input  logic [1:0]           i_addr_lo,
    input  logic [REG_BUS-1:0]   i_reg2,
    input  logic [REG_BUS-1:0]   i_rdata,
    output logic [3:0]           o_sel,
    output logic [REG_BUS-1:0]   o_sdata,
    output logic [REG_BUS-1:0]   o_ldata,
    output logic                 o_is_mem,
    output logic                 o_is_load,
    output logic                 o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_sel_b;
    logic [3:0]  w_sel_h;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
    end

    assign w_half  = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    assign w_sel_b = 4'b0001 << i_addr_lo;
    assign w_sel_h = i_addr_lo[1] ? 4'b1100 : 4'b0011;

    always_comb begin
        o_sel      = 4'b0000;
        o_sdata    = i_reg2;
        o_ldata    = i_rdata;
        o_is_mem   = 1'b1;
        o_is_load  = 1'b1;
        o_misalign = 1'b0;
        case (i_aluop)
            EXE_LB_OP:  begin o_sel = w_sel_b; o_ldata = {{24{w_byte[7]}}, w_byte}; end
            EXE_LBU_OP: begin o_sel = w_sel_b; o_ldata = {24'b0, w_byte}; end
            EXE_LH_OP:  begin
                o_sel = w_sel_h; o_ldata = {{16{w_half[15]}}, w_half}; o_misalign = i_addr_lo[0];
            end
            EXE_LHU_OP: begin
                o_sel = w_sel_h; o_ldata = {16'b0, w_half}; o_misalign = i_addr_lo[0];
            end
            EXE_LW_OP:  begin o_sel = 4'b1111; o_misalign = |i_addr_lo; end
            EXE_SB_OP:  begin o_is_load = 1'b0; o_sel = w_sel_b; o_sdata = {4{i_reg2[7:0]}}; end
            EXE_SH_OP:  begin
                o_is_load = 1'b0; o_sel = w_sel_h; o_sdata = {2{i_reg2[15:0]}};
                o_misalign = i_addr_lo[0];
            end
            EXE_SW_OP:  begin o_is_load = 1'b0; o_sel = 4'b1111; o_misalign = |i_addr_lo; end
            default:    begin o_is_mem = 1'b0; o_is_load = 1'b0; end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage: runs loads/stores as single Wishbone classic cycles, stalls the
// pipeline while the cycle is outstanding, and forms the MEM/WB result.
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic                    flush,
    input  logic [REG_ADDR_BUS-1:0] mem_wd,
    input  logic                    mem_wreg,
    input  logic [REG_BUS-1:0]      mem_wdata,
    input  logic [ALUOP_BUS-1:0]    mem_aluop,
    input  logic [REG_BUS-1:0]      mem_mem_addr,
    input  logic [REG_BUS-1:0]      mem_reg2,
    input  logic [REG_BUS-1:0]      mem_excepttype,
    input  logic [REG_BUS-1:0]      mem_current_inst_address,
    output logic [REG_ADDR_BUS-1:0] wb_wd,
    output logic                    wb_wreg,
    output logic [REG_BUS-1:0]      wb_wdata,
    output logic [REG_BUS-1:0]      excepttype_o,
    output logic [REG_BUS-1:0]      current_inst_address_o,
    output logic                    stallreq,
    output logic [REG_BUS-1:0]      wishbone_addr_o,
    output logic [REG_BUS-1:0]      wishbone_data_o,
    output logic [3:0]              wishbone_sel_o,
    output logic                    wishbone_we_o,
    output logic                    wishbone_stb_o,
    output logic                    wishbone_cyc_o,
    input  logic [REG_BUS-1:0]      wishbone_data_i,
    input  logic                    wishbone_ack_i
);

    lsu_state_e         r_state;
    logic               r_cyc, r_stb, r_we, r_flushed;
    logic [REG_BUS-1:0] r_addr, r_data, r_rdata;
    logic [3:0]         r_sel;

    logic [3:0]         w_sel;
    logic [REG_BUS-1:0] w_sdata, w_ldata;
    logic               w_is_mem, w_is_load, w_misalign, w_valid;
    logic               w_unused;

    assign w_unused = ^{stall[5], stall[3:0]};

    lsu_align u_align (
        .i_aluop    (mem_aluop),
        .i_addr_lo  (mem_mem_addr[1:0]),
        .i_reg2     (mem_reg2),
        .i_rdata    (r_rdata),
        .o_sel      (w_sel),
        .o_sdata    (w_sdata),
        .o_ldata    (w_ldata),
        .o_is_mem   (w_is_mem),
        .o_is_load  (w_is_load),
        .o_misalign (w_misalign)
    );

    // Earlier-stage exceptions and misalignment both keep the access off the bus.
    assign w_valid = w_is_mem & ~w_misalign & (mem_excepttype == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= LSU_IDLE;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_flushed <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_rdata   <= '0;
            r_sel     <= 4'b0000;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    r_flushed <= 1'b0;
                    if (w_valid && !flush) begin
                        r_state <= LSU_BUSY;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_addr  <= {mem_mem_addr[REG_BUS-1:2], 2'b00};
                        r_sel   <= w_sel;
                        r_we    <= ~w_is_load;
                        r_data  <= w_sdata;
                    end
                end
                LSU_BUSY: begin
                    // A flushed cycle still runs to ack; its data is thrown away.
                    if (flush) r_flushed <= 1'b1;
                    if (wishbone_ack_i) begin
                        r_cyc <= 1'b0;
                        r_stb <= 1'b0;
                        if (flush || r_flushed) begin
                            r_state <= LSU_IDLE;
                        end else begin
                            r_state <= LSU_DONE;
                            r_rdata <= wishbone_data_i;
                        end
                    end
                end
                LSU_DONE: begin
                    if (flush || stall[4] == NO_STOP) r_state <= LSU_IDLE;
                end
                default: r_state <= LSU_IDLE;
            endcase
        end
    end

    assign wishbone_addr_o = r_addr;
    assign wishbone_data_o = r_data;
    assign wishbone_sel_o  = r_sel;
    assign wishbone_we_o   = r_we;
    assign wishbone_stb_o  = r_stb;
    assign wishbone_cyc_o  = r_cyc;

    assign stallreq = ((r_state == LSU_IDLE) & w_valid & ~flush) | (r_state == LSU_BUSY);
    assign current_inst_address_o = mem_current_inst_address;

    always_comb begin
        excepttype_o = mem_excepttype;
        if (w_misalign && w_is_load)  excepttype_o[EXC_LOAD_MISALIGN]  = 1'b1;
        if (w_misalign && !w_is_load) excepttype_o[EXC_STORE_MISALIGN] = 1'b1;
    end

    always_comb begin
        wb_wd    = mem_wd;
        wb_wreg  = mem_wreg;
        wb_wdata = mem_wdata;
        if (w_is_mem) begin
            if (r_state == LSU_DONE) begin
                wb_wreg  = w_is_load & mem_wreg;
                wb_wdata = w_ldata;
            end else begin
                wb_wreg  = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomised and directed bench for mem_lsu with a wait-state Wishbone slave
// and a lane/extension reference model computed with plain arithmetic.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr, mem_reg2, mem_excepttype, mem_current_inst_address;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata, excepttype_o, current_inst_address_o;
    logic        stallreq;
    logic [31:0] wishbone_addr_o, wishbone_data_o, wishbone_data_i;
    logic [3:0]  wishbone_sel_o;
    logic        wishbone_we_o, wishbone_stb_o, wishbone_cyc_o, wishbone_ack_i;

    int          n_cmp = 0;
    int          n_err = 0;
    int          slv_waits = 0;
    logic [31:0] slv_rdata = 32'h0;
    logic [3:0]  wcnt;

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .mem_excepttype(mem_excepttype), .mem_current_inst_address(mem_current_inst_address),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .excepttype_o(excepttype_o), .current_inst_address_o(current_inst_address_o),
        .stallreq(stallreq),
        .wishbone_addr_o(wishbone_addr_o), .wishbone_data_o(wishbone_data_o),
        .wishbone_sel_o(wishbone_sel_o), .wishbone_we_o(wishbone_we_o),
        .wishbone_stb_o(wishbone_stb_o), .wishbone_cyc_o(wishbone_cyc_o),
        .wishbone_data_i(wishbone_data_i), .wishbone_ack_i(wishbone_ack_i)
    );

    // Slave: acks after slv_waits cycles of stb; read data is junk except on ack.
    assign wishbone_ack_i  = wishbone_cyc_o & wishbone_stb_o & (int'(wcnt) == slv_waits);
    assign wishbone_data_i = wishbone_ack_i ? slv_rdata : 32'h5A5A_A5A5;

    always @(posedge clk or negedge rst) begin
        if (!rst) wcnt <= 4'd0;
        else if (wishbone_cyc_o && wishbone_stb_o && !wishbone_ack_i) wcnt <= wcnt + 4'd1;
        else wcnt <= 4'd0;
    end

    function automatic void model(input logic [7:0] op, input logic [31:0] addr, reg2, rd,
                                  output bit is_ld, output bit mis, output logic [3:0] sel,
                                  output logic [31:0] sd, output logic [31:0] ld);
        int size, b, base;
        bit sgn;
        longint unsigned v, m;
        b = int'(addr % 4);
        is_ld = 1'b1; sgn = 1'b0; size = 4;
        case (op)
            EXE_LB_OP:  begin size = 1; sgn = 1'b1; end
            EXE_LBU_OP: size = 1;
            EXE_LH_OP:  begin size = 2; sgn = 1'b1; end
            EXE_LHU_OP: size = 2;
            EXE_LW_OP:  size = 4;
            EXE_SB_OP:  begin size = 1; is_ld = 1'b0; end
            EXE_SH_OP:  begin size = 2; is_ld = 1'b0; end
            default:    begin size = 4; is_ld = 1'b0; end
        endcase
        mis  = (b % size) != 0;
        base = b - (b % size);
        sel  = 4'(((1 << size) - 1) << base);
        case (size)
            1:       sd = {24'b0, reg2[7:0]} * 32'h0101_0101;
            2:       sd = {16'b0, reg2[15:0]} * 32'h0001_0001;
            default: sd = reg2;
        endcase
        m = (64'd1 << (8 * size)) - 64'd1;
        v = ({32'b0, rd} >> (8 * base)) & m;
        if (sgn && v > m / 2) v = v - (m + 64'd1);
        ld = v[31:0];
    endfunction

    task automatic run_access(input string tag, input logic [7:0] op, input logic [31:0] addr,
                              input logic [31:0] reg2, input logic [31:0] rd,
                              input int waits, input int hold);
        bit          ld_op, mis;
        logic [3:0]  esel;
        logic [31:0] esd, eld, eexc;
        int          nst;
        model(op, addr, reg2, rd, ld_op, mis, esel, esd, eld);
        eexc = mis ? (ld_op ? 32'h10 : 32'h20) : 32'h0;
        slv_waits = waits; slv_rdata = rd;
        mem_aluop = op; mem_mem_addr = addr; mem_reg2 = reg2;
        mem_wd = 5'($urandom); mem_wreg = 1'b1; mem_wdata = $urandom;
        mem_excepttype = 32'h0; flush = 1'b0; stall = 6'b0;
        #3;
        n_cmp++; if (excepttype_o !== eexc) begin n_err++;
            $display("FAIL %s excepttype: got %h exp %h", tag, excepttype_o, eexc); end
        if (mis) begin
            n_cmp++; if (stallreq !== 1'b0) begin n_err++;
                $display("FAIL %s mis_stallreq: got %b exp 0", tag, stallreq); end
            n_cmp++; if (wb_wreg !== 1'b0) begin n_err++;
                $display("FAIL %s mis_wreg: got %b exp 0", tag, wb_wreg); end
            @(posedge clk); #3;
            n_cmp++; if (wishbone_cyc_o !== 1'b0) begin n_err++;
                $display("FAIL %s mis_cyc: got %b exp 0", tag, wishbone_cyc_o); end
        end else begin
            nst = 0;
            while (stallreq === 1'b1 && nst < 40) begin
                nst++;
                if (nst == 1) begin
                    n_cmp++; if (wishbone_cyc_o !== 1'b0 || wb_wreg !== 1'b0) begin n_err++;
                        $display("FAIL %s idle_detect: got cyc=%b wreg=%b exp 0/0", tag, wishbone_cyc_o, wb_wreg); end
                end else begin
                    n_cmp++;
                    if (wishbone_cyc_o !== 1'b1 || wishbone_stb_o !== 1'b1 || wishbone_addr_o !== (addr & 32'hFFFF_FFFC)
                        || wishbone_sel_o !== esel || wishbone_we_o !== !ld_op || (!ld_op && wishbone_data_o !== esd)
                        || wb_wreg !== 1'b0) begin
                        n_err++;
                        $display("FAIL %s bus: got cyc=%b stb=%b addr=%h sel=%b we=%b data=%h wreg=%b exp 1/1/%h/%b/%b/%h/0",
                                 tag, wishbone_cyc_o, wishbone_stb_o, wishbone_addr_o, wishbone_sel_o, wishbone_we_o,
                                 wishbone_data_o, wb_wreg, addr & 32'hFFFF_FFFC, esel, !ld_op, esd);
                    end
                end
                @(posedge clk); #3;
            end
            n_cmp++; if (nst != waits + 2) begin n_err++;
                $display("FAIL %s stall_cycles: got %0d exp %0d", tag, nst, waits + 2); end
            n_cmp++; if (wishbone_cyc_o !== 1'b0 || wb_wreg !== ld_op) begin n_err++;
                $display("FAIL %s done: got cyc=%b wreg=%b exp 0/%b", tag, wishbone_cyc_o, wb_wreg, ld_op); end
            if (ld_op) begin
                n_cmp++; if (wb_wdata !== eld) begin n_err++;
                    $display("FAIL %s load_data: got %h exp %h", tag, wb_wdata, eld); end
            end
            if (hold > 0) begin
                stall[4] = STOP;
                repeat (hold) begin
                    @(posedge clk); #3;
                    n_cmp++;
                    if (stallreq !== 1'b0 || wb_wreg !== ld_op || (ld_op && wb_wdata !== eld)) begin n_err++;
                        $display("FAIL %s hold: got stallreq=%b wreg=%b wdata=%h exp 0/%b/%h", tag, stallreq, wb_wreg, wb_wdata, ld_op, eld); end
                end
                stall[4] = NO_STOP;
            end
        end
        @(posedge clk); #1;
        mem_aluop = EXE_NOP_OP;
        #3;
        n_cmp++; if (wishbone_cyc_o !== 1'b0 || stallreq !== 1'b0) begin n_err++;
            $display("FAIL %s idle_after: got cyc=%b stallreq=%b exp 0/0", tag, wishbone_cyc_o, stallreq); end
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 6'b0; flush = 1'b0;
        mem_aluop = EXE_NOP_OP; mem_wd = 5'd7; mem_wreg = 1'b1; mem_wdata = 32'h1234_5678;
        mem_mem_addr = 32'h0; mem_reg2 = 32'h0; mem_excepttype = 32'h0; mem_current_inst_address = 32'h40;
        #12;
        n_cmp++;
        if (wishbone_cyc_o !== 1'b0 || wishbone_stb_o !== 1'b0 || wishbone_we_o !== 1'b0
            || wishbone_addr_o !== 32'h0 || wishbone_data_o !== 32'h0 || wishbone_sel_o !== 4'h0) begin
            n_err++;
            $display("FAIL reset_bus: got cyc=%b stb=%b we=%b addr=%h data=%h sel=%b exp all zero",
                     wishbone_cyc_o, wishbone_stb_o, wishbone_we_o, wishbone_addr_o, wishbone_data_o, wishbone_sel_o);
        end
        n_cmp++;
        if (stallreq !== 1'b0 || wb_wd !== 5'd7 || wb_wreg !== 1'b1 || wb_wdata !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL reset_wb: got stallreq=%b wd=%0d wreg=%b wdata=%h exp 0/7/1/12345678", stallreq, wb_wd, wb_wreg, wb_wdata);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_passthrough();
        logic [31:0] exc;
        for (int i = 0; i < 6; i++) begin
            exc = (i % 2 == 0) ? 32'h0 : ($urandom & 32'hFFFF_FFCF);
            mem_aluop = EXE_ADD_OP; mem_wd = 5'($urandom); mem_wreg = 1'($urandom);
            mem_wdata = $urandom; mem_mem_addr = $urandom; mem_reg2 = $urandom;
            mem_excepttype = exc; mem_current_inst_address = $urandom;
            #2;
            n_cmp++;
            if (wb_wd !== mem_wd || wb_wreg !== mem_wreg || wb_wdata !== mem_wdata || stallreq !== 1'b0
                || excepttype_o !== exc || current_inst_address_o !== mem_current_inst_address) begin
                n_err++;
                $display("FAIL passthru: got wd=%0d wreg=%b wdata=%h stallreq=%b exc=%h exp %0d/%b/%h/0/%h",
                         wb_wd, wb_wreg, wb_wdata, stallreq, excepttype_o, mem_wd, mem_wreg, mem_wdata, exc);
            end
            @(posedge clk); #1;
            n_cmp++; if (wishbone_cyc_o !== 1'b0) begin n_err++;
                $display("FAIL passthru_cyc: got %b exp 0", wishbone_cyc_o); end
        end
        mem_excepttype = 32'h0;
    endtask

    task automatic test_store_word();
        run_access("sw", EXE_SW_OP, 32'h100, 32'hDEAD_BEEF, $urandom, 2, 0);
    endtask

    task automatic test_loads();
        run_access("lb",  EXE_LB_OP,  32'h103, 32'h0, 32'h80FF_FF7F, 0, 0);
        run_access("lbu", EXE_LBU_OP, 32'h103, 32'h0, 32'h80FF_FF7F, 0, 0);
        run_access("lh",  EXE_LH_OP,  32'h102, 32'h0, 32'h80FF_FF7F, 1, 0);
        run_access("lhu", EXE_LHU_OP, 32'h100, 32'h0, 32'h1234_F00D, 0, 0);
        run_access("sb",  EXE_SB_OP,  32'h102, 32'hAB, 32'h0, 0, 0);
        run_access("sh",  EXE_SH_OP,  32'h102, 32'h1234_5678, 32'h0, 1, 0);
    endtask

    task automatic test_misalign();
        run_access("mis_lw", EXE_LW_OP, 32'h102, 32'h0, 32'h0, 0, 0);
        run_access("mis_lh", EXE_LH_OP, 32'h101, 32'h0, 32'h0, 0, 0);
        run_access("mis_sh", EXE_SH_OP, 32'h103, 32'h0, 32'h0, 0, 0);
        run_access("mis_sw", EXE_SW_OP, 32'h101, 32'h0, 32'h0, 0, 0);
    endtask

    task automatic test_exc_suppress();
        mem_aluop = EXE_LW_OP; mem_mem_addr = 32'h200; mem_wreg = 1'b1; mem_excepttype = 32'h0000_0100;
        #3;
        n_cmp++; if (stallreq !== 1'b0 || wb_wreg !== 1'b0 || excepttype_o !== 32'h0000_0100) begin n_err++;
            $display("FAIL exc_suppress: got stallreq=%b wreg=%b exc=%h exp 0/0/00000100", stallreq, wb_wreg, excepttype_o); end
        @(posedge clk); #3;
        n_cmp++; if (wishbone_cyc_o !== 1'b0) begin n_err++;
            $display("FAIL exc_suppress_cyc: got %b exp 0", wishbone_cyc_o); end
        mem_excepttype = 32'h0; mem_aluop = EXE_NOP_OP;
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        int n;
        mem_aluop = EXE_LW_OP; mem_mem_addr = 32'h200; mem_wreg = 1'b1; mem_excepttype = 32'h0;
        slv_waits = 3; slv_rdata = 32'hCAFE_F00D; flush = 1'b1;
        #3;
        n_cmp++; if (stallreq !== 1'b0) begin n_err++;
            $display("FAIL flush_idle_stallreq: got %b exp 0", stallreq); end
        @(posedge clk); #3;
        n_cmp++; if (wishbone_cyc_o !== 1'b0) begin n_err++;
            $display("FAIL flush_idle_cyc: got %b exp 0", wishbone_cyc_o); end
        flush = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (wishbone_cyc_o !== 1'b1) begin n_err++;
            $display("FAIL flush_busy_start: got cyc=%b exp 1", wishbone_cyc_o); end
        flush = 1'b1;
        n = 0;
        while (wishbone_cyc_o === 1'b1 && n < 20) begin n++; @(posedge clk); #1; end
        n_cmp++; if (n != 4) begin n_err++;
            $display("FAIL flush_hold: got %0d cycles exp 4", n); end
        n_cmp++; if (wb_wreg !== 1'b0 || stallreq !== 1'b0) begin n_err++;
            $display("FAIL flush_no_write: got wreg=%b stallreq=%b exp 0/0", wb_wreg, stallreq); end
        flush = 1'b0; mem_aluop = EXE_NOP_OP;
        @(posedge clk); #3;
        n_cmp++; if (wishbone_cyc_o !== 1'b0) begin n_err++;
            $display("FAIL flush_idle_after: got %b exp 0", wishbone_cyc_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_busy();
        mem_aluop = EXE_SW_OP; mem_mem_addr = 32'h300; mem_reg2 = 32'h1111_2222;
        slv_waits = 5; flush = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (wishbone_cyc_o !== 1'b1) begin n_err++;
            $display("FAIL rst_busy_start: got cyc=%b exp 1", wishbone_cyc_o); end
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (wishbone_cyc_o !== 1'b0 || wishbone_stb_o !== 1'b0 || wishbone_we_o !== 1'b0) begin n_err++;
            $display("FAIL rst_busy_drop: got cyc=%b stb=%b we=%b exp 0/0/0", wishbone_cyc_o, wishbone_stb_o, wishbone_we_o); end
        mem_aluop = EXE_NOP_OP;
        #1 rst = 1'b1;
        @(posedge clk); #3;
        n_cmp++; if (wishbone_cyc_o !== 1'b0 || stallreq !== 1'b0) begin n_err++;
            $display("FAIL rst_busy_idle: got cyc=%b stallreq=%b exp 0/0", wishbone_cyc_o, stallreq); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall_hold();
        run_access("hold_lh", EXE_LH_OP, 32'h1F2, 32'h0, 32'h8001_7FFE, 0, 3);
        run_access("hold_sw", EXE_SW_OP, 32'h1F4, 32'h0BAD_CAFE, 32'h0, 1, 2);
    endtask

    task automatic test_random();
        logic [7:0] ops [8];
        ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
        for (int i = 0; i < 30; i++) begin
            run_access("rand", ops[$urandom_range(0, 7)], 32'h1000 + $urandom_range(0, 63),
                       $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_passthrough();
        test_store_word();
        test_loads();
        test_misalign();
        test_exc_suppress();
        test_flush();
        test_reset_busy();
        test_stall_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
